mux_n_reg: RTL and testbench

Parametrised N-to-1 multiplexer that generalises the 4:1 datapath selectors. It adds a latched select register, a registered output with load enable, a valid pulse, and sticky illegal-select detection for non-power-of-two input counts. It sits between datapath sources (register file, ALU, shifter, memory data register) and their consumers where a stable, registered selection is needed across multicycle control states.

---
 rtl/mux_n_reg_if.sv | 27 ++
 rtl/mux_n_reg.sv | 71 +++++++
 tb/tb_mux_n_reg.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mux_n_reg_if.sv
// Bus bundle for mux_n_reg: source-side data/control and the registered results.
// The master modport belongs to the driving controller; the slave modport belongs to the mux.
interface mux_n_reg_if #(
   parameter int WIDTH = 32,
   parameter int N_IN  = 4,
   parameter int SEL_W = 2
);
   logic [N_IN*WIDTH-1:0] data_in;
   logic [SEL_W-1:0]      sel;
   logic                  sel_load;
   logic                  out_en;
   logic                  err_clr;
   logic [WIDTH-1:0]      out;
   logic [SEL_W-1:0]      sel_q;
   logic                  out_valid;
   logic                  sel_err;

   modport master (
      output data_in, sel, sel_load, out_en, err_clr,
      input  out, sel_q, out_valid, sel_err
   );

   modport slave (
      input  data_in, sel, sel_load, out_en, err_clr,
      output out, sel_q, out_valid, sel_err
   );
endinterface

// File: rtl/mux_n_reg.sv
// Registered N:1 selector with a latched select, a bypass on select load, a valid pulse
// and a sticky flag for captures attempted with an out-of-range select.
module mux_n_reg #(
   parameter int               WIDTH     = 32,
   parameter int               N_IN      = 4,
   parameter int               SEL_W     = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input logic        clk,
   input logic        reset,
   mux_n_reg_if.slave bus
);

   if (N_IN < 2 || N_IN > 16 || SEL_W < $clog2(N_IN)) begin : g_cfg_err
      $error("mux_n_reg: illegal N_IN/SEL_W combination");
   end

   logic [SEL_W-1:0] r_sel_q;
   logic [WIDTH-1:0] r_out;
   logic             r_out_valid;
   logic             r_sel_err;

   logic [SEL_W-1:0] w_eff_sel;
   logic             w_legal;
   logic [WIDTH-1:0] w_sel_data;
   logic             w_capture;
   logic             w_illegal;

   // A select being loaded this cycle is used immediately, not only from the next edge.
   always_comb begin
      w_eff_sel  = bus.sel_load ? bus.sel : r_sel_q;
      w_legal    = (32'(w_eff_sel) < 32'(N_IN));
      w_sel_data = '0;
      for (int unsigned k = 0; k < N_IN; k++) begin
         if (w_eff_sel == SEL_W'(k)) begin
            w_sel_data = bus.data_in[k*WIDTH +: WIDTH];
         end
      end
      w_capture  = bus.out_en && w_legal;
      w_illegal  = bus.out_en && !w_legal;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out       <= RESET_VAL;
         r_sel_q     <= '0;
         r_out_valid <= 1'b0;
         r_sel_err   <= 1'b0;
      end else begin
         if (bus.sel_load) begin
            r_sel_q <= bus.sel;
         end
         if (w_capture) begin
            r_out <= w_sel_data;
         end
         r_out_valid <= w_capture;
         // A new illegal capture outranks a simultaneous clear.
         if (w_illegal) begin
            r_sel_err <= 1'b1;
         end else if (bus.err_clr) begin
            r_sel_err <= 1'b0;
         end
      end
   end

   assign bus.out       = r_out;
   assign bus.sel_q     = r_sel_q;
   assign bus.out_valid = r_out_valid;
   assign bus.sel_err   = r_sel_err;

endmodule

// File: tb/tb_mux_n_reg.sv
// Directed bench for mux_n_reg: a 4-input instance (power-of-two) and a 3-input
// instance (with an unreachable select code), checked against hand-computed values.
module tb_mux_n_reg;

   logic clk;
   logic reset;

   mux_n_reg_if #(.WIDTH(32), .N_IN(4), .SEL_W(2)) ifa ();
   mux_n_reg_if #(.WIDTH(32), .N_IN(3), .SEL_W(2)) ifb ();

   mux_n_reg #(
      .WIDTH(32), .N_IN(4), .SEL_W(2), .RESET_VAL(32'hDEADBEEF)
   ) u_dut_a (
      .clk(clk), .reset(reset), .bus(ifa)
   );

   mux_n_reg #(
      .WIDTH(32), .N_IN(3), .SEL_W(2), .RESET_VAL(32'h0)
   ) u_dut_b (
      .clk(clk), .reset(reset), .bus(ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] a_vals [4];

   initial begin
      a_vals[0] = 32'h11; a_vals[1] = 32'h22; a_vals[2] = 32'h33; a_vals[3] = 32'h44;

      reset = 1'b1;
      ifa.data_in = {32'h44, 32'h33, 32'h22, 32'h11};
      ifa.sel = '0; ifa.sel_load = 0; ifa.out_en = 0; ifa.err_clr = 0;
      ifb.data_in = {32'hC3, 32'h22, 32'hA1};
      ifb.sel = '0; ifb.sel_load = 0; ifb.out_en = 0; ifb.err_clr = 0;

      // Async reset: checked before the first clock edge at t=5
      #1;
      check("rst_a_out",   ifa.out, 32'hDEADBEEF);
      check("rst_a_selq",  32'(ifa.sel_q), 32'd0);
      check("rst_a_valid", 32'(ifa.out_valid), 32'd0);
      check("rst_a_err",   32'(ifa.sel_err), 32'd0);
      check("rst_b_out",   ifb.out, 32'h0);
      #1 reset = 1'b0;

      // Sweep all selects with load+capture on the same edge
      for (int k = 0; k < 4; k++) begin
         ifa.sel = 2'(k); ifa.sel_load = 1; ifa.out_en = 1;
         tick();
         check($sformatf("sweep%0d_out", k), ifa.out, a_vals[k]);
         check($sformatf("sweep%0d_valid", k), 32'(ifa.out_valid), 32'd1);
         check($sformatf("sweep%0d_selq", k), 32'(ifa.sel_q), 32'(k));
         ifa.sel_load = 0; ifa.out_en = 0;
         tick();
         check($sformatf("sweep%0d_pulse", k), 32'(ifa.out_valid), 32'd0);
         check($sformatf("sweep%0d_hold", k), ifa.out, a_vals[k]);
      end
      check("a_never_err", 32'(ifa.sel_err), 32'd0);

      // Held select with changing data
      ifa.sel = 2'd2; ifa.sel_load = 1;
      tick();
      check("held_selq", 32'(ifa.sel_q), 32'd2);
      check("held_noen", ifa.out, 32'h44);
      ifa.sel = 2'd0; ifa.sel_load = 0; ifa.out_en = 1;
      ifa.data_in[64 +: 32] = 32'h55;
      tick();
      check("held_out", ifa.out, 32'h55);
      check("held_valid", 32'(ifa.out_valid), 32'd1);
      ifa.out_en = 0;
      ifa.data_in[64 +: 32] = 32'h66;
      tick();
      check("held_stay", ifa.out, 32'h55);
      check("held_vlow", 32'(ifa.out_valid), 32'd0);
      tick();
      check("held_stay2", ifa.out, 32'h55);

      // Illegal select on the 3-input instance
      ifb.sel = 2'd1; ifb.sel_load = 1; ifb.out_en = 1;
      tick();
      check("b_pre_out", ifb.out, 32'h22);
      ifb.data_in[32 +: 32] = 32'h77;
      ifb.sel = 2'd3;
      tick();
      check("ill_out", ifb.out, 32'h22);
      check("ill_valid", 32'(ifb.out_valid), 32'd0);
      check("ill_err", 32'(ifb.sel_err), 32'd1);
      check("ill_selq", 32'(ifb.sel_q), 32'd3);
      ifb.sel = 2'd1;
      tick();
      check("post_ill_out", ifb.out, 32'h77);
      check("post_ill_valid", 32'(ifb.out_valid), 32'd1);
      check("post_ill_err", 32'(ifb.sel_err), 32'd1);

      // Illegal from the latched select without a load
      ifb.sel = 2'd3; ifb.sel_load = 1; ifb.out_en = 0;
      tick();
      check("latch_ill_selq", 32'(ifb.sel_q), 32'd3);
      ifb.sel = 2'd0; ifb.sel_load = 0; ifb.out_en = 1;
      tick();
      check("latch_ill_out", ifb.out, 32'h77);
      check("latch_ill_valid", 32'(ifb.out_valid), 32'd0);

      // Clear/set race: set wins, then a plain clear
      ifb.sel = 2'd3; ifb.sel_load = 1; ifb.out_en = 1; ifb.err_clr = 1;
      tick();
      check("race_err", 32'(ifb.sel_err), 32'd1);
      ifb.sel_load = 0; ifb.out_en = 0; ifb.err_clr = 1;
      tick();
      check("clr_err", 32'(ifb.sel_err), 32'd0);
      ifb.err_clr = 0;
      tick();
      check("clr_stays", 32'(ifb.sel_err), 32'd0);

      // Reset mid-stream, half a cycle long, between edges
      ifa.out_en = 1; ifa.sel_load = 1; ifa.sel = 2'd1;
      tick();
      check("stream1", ifa.out, 32'h22);
      ifa.sel = 2'd3;
      tick();
      check("stream3", ifa.out, 32'h44);
      check("stream3_selq", 32'(ifa.sel_q), 32'd3);
      #1 reset = 1'b1;
      #1;
      check("mid_rst_out", ifa.out, 32'hDEADBEEF);
      check("mid_rst_selq", 32'(ifa.sel_q), 32'd0);
      check("mid_rst_valid", 32'(ifa.out_valid), 32'd0);
      check("mid_rst_b_err", 32'(ifb.sel_err), 32'd0);
      ifa.sel_load = 0; ifa.sel = 2'd3;
      #3 reset = 1'b0;
      tick();
      check("after_rst_out", ifa.out, 32'h11);
      check("after_rst_valid", 32'(ifa.out_valid), 32'd1);
      check("after_rst_selq", 32'(ifa.sel_q), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
